// File: rtl/lock_chk_pkg.sv
// Shared types and helpers for the XOR-lock response checker.
// Holds the epoch FSM encoding, default widths and the saturation helper.
// Build option LOCK_CHK_BITMAP_EN (see top) does not affect this package.
package lock_chk_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    REPORT = 2'd3
  } state_e;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_CNT_W = 16;
  localparam int unsigned DEF_HD_W  = 24;

  // Saturating-increment helper: true when a + inc would pass the all-ones
  // value of a w-bit counter, so the caller clamps instead of wrapping.
  function automatic logic sat_inc_ovf(input logic [63:0] a,
                                       input logic [63:0] inc,
                                       input int unsigned w);
    logic [63:0] max_v;
    logic [64:0] sum_v;
    max_v = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    sum_v = {1'b0, a} + {1'b0, inc};
    return (sum_v > {1'b0, max_v});
  endfunction

endpackage

// File: rtl/lock_chk_popcount.sv
// Combinational population count of an N-bit vector.
// Latency: zero cycles (pure combinational).
// Backpressure: none; result follows the input directly.
module lock_chk_popcount #(
  parameter int unsigned N = 33,
  localparam int unsigned OUT_W = $clog2(N + 1)
) (
  input  logic [N-1:0]     vec_i,
  output logic [OUT_W-1:0] cnt_o
);

  // Ripple sum of the individual bits; synthesis builds an adder tree.
  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < N; i++) begin
      cnt_o = cnt_o + OUT_W'(vec_i[i]);
    end
  end

endmodule

// File: rtl/lock_response_checker.sv
// Compares locked-adder results against a recomputed golden sum, per key epoch.
// Latency: counters reflect a vector 2 edges after acceptance; 1 vector/cycle.
// Backpressure: ready only in RUN; optional LOCK_CHK_BITMAP_EN adds err_bitmap_o.
module lock_response_checker
  import lock_chk_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W,
  parameter int unsigned HD_W  = DEF_HD_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             end_i,
  input  logic             vec_valid_i,
  output logic             vec_ready_o,
  input  logic [WIDTH-1:0] add1_i,
  input  logic [WIDTH-1:0] add2_i,
  input  logic [WIDTH:0]   result_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] vec_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [HD_W-1:0]  hd_sum_o,
  output logic [CNT_W-1:0] first_err_idx_o,
`ifdef LOCK_CHK_BITMAP_EN
  output logic [WIDTH:0]   err_bitmap_o,
`endif
  output logic             err_seen_o
);

  localparam int unsigned RW   = WIDTH + 1;
  localparam int unsigned PC_W = $clog2(WIDTH + 2);

  state_e state_q, state_d;

  logic            s1_vld_q, s2_vld_q;
  logic [RW-1:0]   res_q, gold_q, diff_q;
  logic [PC_W-1:0] pc_q;
  logic [RW-1:0]   s1_diff, gold;
  logic [PC_W-1:0] s1_pc;

  logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d, err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] first_idx_q, first_idx_d;
  logic [HD_W-1:0]  hd_sum_q, hd_sum_d;
  logic             err_seen_q, err_seen_d;

  logic accept, clear_epoch;

  assign accept      = vec_valid_i & (state_q == RUN);
  assign clear_epoch = (state_q == IDLE) & start_i;
  assign gold        = RW'(add1_i) + RW'(add2_i);
  assign s1_diff     = res_q ^ gold_q;

  lock_chk_popcount #(.N(RW)) u_popcount (
    .vec_i (s1_diff),
    .cnt_o (s1_pc)
  );

  // Epoch FSM next state: DRAIN waits for both pipeline stages to empty.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = RUN;
      RUN:     if (end_i) state_d = DRAIN;
      DRAIN:   if (!s1_vld_q && !s2_vld_q) state_d = REPORT;
      REPORT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM register and the two compare pipeline stages.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
      res_q    <= '0;
      gold_q   <= '0;
      diff_q   <= '0;
      pc_q     <= '0;
    end else begin
      state_q  <= state_d;
      s1_vld_q <= accept;
      s2_vld_q <= s1_vld_q;
      if (accept) begin
        res_q  <= result_i;
        gold_q <= gold;
      end
      if (s1_vld_q) begin
        diff_q <= s1_diff;
        pc_q   <= s1_pc;
      end
    end
  end

  // Accumulate stage: saturating counters; the index is the pre-increment count.
  always_comb begin
    vec_cnt_d   = vec_cnt_q;
    err_cnt_d   = err_cnt_q;
    hd_sum_d    = hd_sum_q;
    first_idx_d = first_idx_q;
    err_seen_d  = err_seen_q;
    if (clear_epoch) begin
      vec_cnt_d   = '0;
      err_cnt_d   = '0;
      hd_sum_d    = '0;
      first_idx_d = '0;
      err_seen_d  = 1'b0;
    end else if (s2_vld_q) begin
      vec_cnt_d = sat_inc_ovf(64'(vec_cnt_q), 64'd1, CNT_W) ? '1 : vec_cnt_q + CNT_W'(1);
      hd_sum_d  = sat_inc_ovf(64'(hd_sum_q), 64'(pc_q), HD_W) ? '1 : hd_sum_q + HD_W'(pc_q);
      if (|diff_q) begin
        err_cnt_d = sat_inc_ovf(64'(err_cnt_q), 64'd1, CNT_W) ? '1 : err_cnt_q + CNT_W'(1);
        if (!err_seen_q) begin
          first_idx_d = vec_cnt_q;
          err_seen_d  = 1'b1;
        end
      end
    end
  end

  // Epoch result registers; they hold through IDLE until the next start.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vec_cnt_q   <= '0;
      err_cnt_q   <= '0;
      hd_sum_q    <= '0;
      first_idx_q <= '0;
      err_seen_q  <= 1'b0;
    end else begin
      vec_cnt_q   <= vec_cnt_d;
      err_cnt_q   <= err_cnt_d;
      hd_sum_q    <= hd_sum_d;
      first_idx_q <= first_idx_d;
      err_seen_q  <= err_seen_d;
    end
  end

`ifdef LOCK_CHK_BITMAP_EN
  logic [RW-1:0] bitmap_q;

  // Sticky record of which output bits the key has corrupted this epoch.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bitmap_q <= '0;
    end else if (clear_epoch) begin
      bitmap_q <= '0;
    end else if (s2_vld_q) begin
      bitmap_q <= bitmap_q | diff_q;
    end
  end

  assign err_bitmap_o = bitmap_q;
`endif

  assign vec_ready_o     = (state_q == RUN);
  assign busy_o          = (state_q != IDLE);
  assign done_o          = (state_q == REPORT);
  assign vec_cnt_o       = vec_cnt_q;
  assign err_cnt_o       = err_cnt_q;
  assign hd_sum_o        = hd_sum_q;
  assign first_err_idx_o = first_idx_q;
  assign err_seen_o      = err_seen_q;

endmodule

// File: tb/tb_lock_response_checker.sv
// Directed bench for lock_response_checker with a cycle-accurate scoreboard.
// Accepted vectors are queued with their acceptance edge and retired 2 edges later.
// Optional LOCK_CHK_BITMAP_EN build also checks err_bitmap_o.
module tb_lock_response_checker;

  localparam int W    = 32;
  localparam int CW   = 4;
  localparam int HW   = 24;
  localparam int RW   = W + 1;
  localparam int CMAX = (1 << CW) - 1;
  localparam int HMAX = (1 << HW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          end_s = 1'b0;
  logic          vld = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [RW-1:0] r = '0;

  logic          rdy, busy, done, seen;
  logic [CW-1:0] vec_cnt, err_cnt, first_idx;
  logic [HW-1:0] hd_sum;
`ifdef LOCK_CHK_BITMAP_EN
  logic [RW-1:0] bitmap;
`endif

  always #5 clk = ~clk;

  lock_response_checker #(.WIDTH(W), .CNT_W(CW), .HD_W(HW)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .start_i         (start),
    .end_i           (end_s),
    .vec_valid_i     (vld),
    .vec_ready_o     (rdy),
    .add1_i          (a),
    .add2_i          (b),
    .result_i        (r),
    .busy_o          (busy),
    .done_o          (done),
    .vec_cnt_o       (vec_cnt),
    .err_cnt_o       (err_cnt),
    .hd_sum_o        (hd_sum),
    .first_err_idx_o (first_idx),
`ifdef LOCK_CHK_BITMAP_EN
    .err_bitmap_o    (bitmap),
`endif
    .err_seen_o      (seen)
  );

  typedef struct {
    int            edge_no;
    logic [RW-1:0] diff;
  } acc_t;

  acc_t          pend_q[$];
  acc_t          pe;
  logic [RW-1:0] tb_gold;
  int            edge_no = 0;
  int            last_acc = -10;
  int            mst = 0;            // 0 idle, 1 run, 2 drain, 3 report
  int            m_vec = 0, m_err = 0, m_hd = 0, m_first = 0;
  logic          m_seen = 1'b0;
  logic [RW-1:0] m_bm = '0;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  // Reference model: epoch FSM plus counters, advanced on each rising edge.
  always @(posedge clk) begin
    edge_no = edge_no + 1;
    if (!rst_n) begin
      mst = 0; last_acc = -10; pend_q.delete();
      m_vec = 0; m_err = 0; m_hd = 0; m_first = 0; m_seen = 1'b0; m_bm = '0;
    end else begin
      case (mst)
        0: if (start) begin
          mst = 1;
          m_vec = 0; m_err = 0; m_hd = 0; m_first = 0; m_seen = 1'b0; m_bm = '0;
        end
        1: begin
          if (vld) begin
            tb_gold = {1'b0, a} + {1'b0, b};
            pe.edge_no = edge_no;
            pe.diff = r ^ tb_gold;
            pend_q.push_back(pe);
            last_acc = edge_no;
          end
          if (end_s) mst = 2;
        end
        2: if (last_acc < edge_no - 2) mst = 3;
        default: mst = 0;
      endcase
      while (pend_q.size() > 0 && pend_q[0].edge_no <= edge_no - 2) begin
        pe = pend_q.pop_front();
        if (pe.diff != '0) begin
          if (!m_seen) begin m_first = m_vec; m_seen = 1'b1; end
          m_err = (m_err < CMAX) ? m_err + 1 : CMAX;
        end
        m_vec = (m_vec < CMAX) ? m_vec + 1 : CMAX;
        m_hd = (m_hd + $countones(pe.diff) > HMAX) ? HMAX : m_hd + $countones(pe.diff);
        m_bm = m_bm | pe.diff;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle: compare every output against the model at the falling edge.
  task automatic step();
    @(negedge clk);
    if (done === 1'b1) done_cnt++;
    check("cyc_busy", 64'(busy), 64'(mst != 0));
    check("cyc_done", 64'(done), 64'(mst == 3));
    check("cyc_rdy", 64'(rdy), 64'(mst == 1));
    check("cyc_vec_cnt", 64'(vec_cnt), 64'(m_vec));
    check("cyc_err_cnt", 64'(err_cnt), 64'(m_err));
    check("cyc_hd_sum", 64'(hd_sum), 64'(m_hd));
    check("cyc_first_idx", 64'(first_idx), 64'(m_first));
    check("cyc_err_seen", 64'(seen), 64'(m_seen));
`ifdef LOCK_CHK_BITMAP_EN
    check("cyc_bitmap", 64'(bitmap), 64'(m_bm));
`endif
    #1;
  endtask

  task automatic put(input logic [W-1:0] x, input logic [W-1:0] y, input logic [RW-1:0] z);
    vld = 1'b1; a = x; b = y; r = z;
  endtask

  task automatic open_epoch();
    start = 1'b1; step(); start = 1'b0;
  endtask

  // Bounded wait for the done pulse, then confirm it lasts exactly one cycle.
  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 20) begin step(); n++; end
    check("done_seen", 64'(done), 64'd1);
    step();
    check("done_pulse_len", 64'(done), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    step(); step();
    check("rst_vec", 64'(vec_cnt), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rdy", 64'(rdy), 64'd0);
    check("rst_hd", 64'(hd_sum), 64'd0);
    rst_n = 1'b1; step();

    // end_i in IDLE is ignored
    end_s = 1'b1; step(); end_s = 1'b0; step();
    check("idle_end_busy", 64'(busy), 64'd0);

    // Correct-key stream
    open_epoch();
    put(32'h29AF2430, 32'h7A1B9ABC, 33'h0_A3CABEEC); step();
    put(32'h1100_3456, 32'h1111_2323, 33'h0_22115779); step();
    vld = 1'b0;
    start = 1'b1; step(); start = 1'b0; step();   // start_i in RUN is ignored
    check("run_start_busy", 64'(busy), 64'd1);
    check("run_start_rdy", 64'(rdy), 64'd1);
    check("run_start_vec", 64'(vec_cnt), 64'd2);
    end_s = 1'b1; step(); end_s = 1'b0;
    wait_done();
    check("ok_vec", 64'(vec_cnt), 64'd2);
    check("ok_err", 64'(err_cnt), 64'd0);
    check("ok_hd", 64'(hd_sum), 64'd0);
    check("ok_seen", 64'(seen), 64'd0);

    // Corrupted output
    open_epoch();
    put(32'h5555_5555, 32'hAAAA_AAAA, 33'h0_00000000); step();
    put(32'h0000_0001, 32'hDEAF_BEEF, 33'h0_DEAFBEF1); step();
    vld = 1'b0; end_s = 1'b1; step(); end_s = 1'b0;
    wait_done();
    check("bad_err", 64'(err_cnt), 64'd2);
    check("bad_hd", 64'(hd_sum), 64'd33);
    check("bad_first", 64'(first_idx), 64'd0);
    check("bad_seen", 64'(seen), 64'd1);
`ifdef LOCK_CHK_BITMAP_EN
    check("bad_bitmap", 64'(bitmap), 64'h0_FFFFFFFF);
`endif
    step();
    check("hold_idle_err", 64'(err_cnt), 64'd2);

    // Handshake and latency, end_i together with the 5th vector
    open_epoch();
    for (int i = 0; i < 5; i++) begin
      put(32'h0100_0000 * (i + 1), 32'h0000_1234 + i, {1'b0, 32'h0100_0000 * (i + 1)} + 33'h0000_1234 + i);
      if (i == 4) end_s = 1'b1;
      step();
      if (i == 1) check("lat_e1", 64'(vec_cnt), 64'd0);
      if (i == 2) check("lat_e2", 64'(vec_cnt), 64'd1);
    end
    end_s = 1'b0;
    put(32'h1, 32'h1, 33'h0);   // presented during DRAIN: must not be taken
    check("drain_rdy", 64'(rdy), 64'd0);
    wait_done();
    vld = 1'b0;
    check("hs_vec", 64'(vec_cnt), 64'd5);
    check("hs_err", 64'(err_cnt), 64'd0);

    // Saturation with 4-bit counters
    open_epoch();
    for (int i = 0; i < 20; i++) begin
      put(32'h5555_5555, 32'hAAAA_AAAA, 33'h0);
      if (i == 19) end_s = 1'b1;
      step();
    end
    vld = 1'b0; end_s = 1'b0;
    wait_done();
    check("sat_vec", 64'(vec_cnt), 64'd15);
    check("sat_err", 64'(err_cnt), 64'd15);
    check("sat_hd", 64'(hd_sum), 64'd640);
    check("sat_first", 64'(first_idx), 64'd0);

    // Reset mid-RUN with vectors in flight
    open_epoch();
    for (int i = 0; i < 3; i++) begin
      put(32'h5555_5555, 32'hAAAA_AAAA, 33'h0); step();
    end
    vld = 1'b0;
    check("pre_rst_err", 64'(err_cnt), 64'd1);
    rst_n = 1'b0; #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_vec", 64'(vec_cnt), 64'd0);
    check("mid_rst_err", 64'(err_cnt), 64'd0);
    check("mid_rst_hd", 64'(hd_sum), 64'd0);
    check("mid_rst_seen", 64'(seen), 64'd0);
    step(); step(); step();
    rst_n = 1'b1; step();
    check("rst_no_done", 64'(done_cnt), 64'd4);
    open_epoch();
    put(32'h29AF2430, 32'h7A1B9ABC, 33'h0_A3CABEEC); step();
    vld = 1'b0; end_s = 1'b1; step(); end_s = 1'b0;
    wait_done();
    check("post_rst_vec", 64'(vec_cnt), 64'd1);
    check("post_rst_err", 64'(err_cnt), 64'd0);
    check("post_rst_seen", 64'(seen), 64'd0);
    check("done_total", 64'(done_cnt), 64'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
